spu_sequencer: RTL

- Multi-cycle controller for the image-equalizer special processing unit (SPU).
- Accepts the 12-bit SPU command decoded by the processor control unit and stalls the ARM core while it runs.
- Sequences three passes over pixel RAM and histogram RAM: histogram build, CDF accumulation, pixel remap.
- Sits between the control unit, pixel memory and histogram memory.

---
 rtl/spu_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spu_sequencer.sv
// Image-equalizer SPU sequencer: histogram build, CDF prefix sum, pixel remap over pixel/histogram RAMs.
// Latency accept->done: HIST 256+3N+1, CDF 513, MAP 3N+1 cycles; stall held combinationally from the accept cycle.
// No backpressure: RAMs answer in one cycle; cmd_valid ignored while busy. SPU_CYCLE_CNT_EN enables cycle_count.
module spu_sequencer #(
   parameter int ADDR_W   = 16,
   parameter int IMG_LOG2 = 12,
   parameter int HIST_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [11:0]       cmd,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              pix_re,
   output logic              pix_we,
   output logic [7:0]        pix_wdata,
   input  logic [7:0]        pix_rdata,
   output logic [7:0]        hist_addr,
   output logic              hist_re,
   output logic              hist_we,
   output logic [HIST_W-1:0] hist_wdata,
   input  logic [HIST_W-1:0] hist_rdata,
   output logic [31:0]       cycle_count
);
   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] CLR   = 4'd1;
   localparam logic [3:0] H_PRD = 4'd2;
   localparam logic [3:0] H_HRD = 4'd3;
   localparam logic [3:0] H_HWR = 4'd4;
   localparam logic [3:0] C_RD  = 4'd5;
   localparam logic [3:0] C_WR  = 4'd6;
   localparam logic [3:0] M_PRD = 4'd7;
   localparam logic [3:0] M_HRD = 4'd8;
   localparam logic [3:0] M_PWR = 4'd9;
   localparam logic [3:0] DONE  = 4'd10;

   localparam logic [ADDR_W:0] K_LAST = (ADDR_W+1)'(2**IMG_LOG2 - 1);

   logic [3:0]        state;
   logic [7:0]        bin;
   logic [ADDR_W:0]   k;
   logic [HIST_W-1:0] sum;
   logic [HIST_W-1:0] sum_nxt;
   logic [ADDR_W-1:0] pix_addr_q;
   logic [7:0]        hist_addr_q;
   logic [3:0]        opcode;
   logic              op_ok;
   logic              accept;
   logic [HIST_W+7:0] prod;
   logic [HIST_W+7:0] scaled;
   logic [7:0]        map_val;
   logic              cmd_unused;

   assign opcode     = cmd[11:8];
   assign cmd_unused = ^cmd[7:0];
   assign op_ok      = (opcode == 4'h1) || (opcode == 4'h2) || (opcode == 4'h3);
   // Gated by reset so stall stays low while reset is held with a command pending.
   assign accept     = reset && (state == IDLE) && cmd_valid && op_ok;
   assign stall      = accept || ((state != IDLE) && (state != DONE));
   assign busy       = (state != IDLE);
   assign sum_nxt    = sum + hist_rdata;

   assign prod    = (HIST_W+8)'(hist_rdata) * (HIST_W+8)'(255);
   assign scaled  = prod >> IMG_LOG2;
   assign map_val = (scaled > (HIST_W+8)'(255)) ? 8'hFF : scaled[7:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bin         <= '0;
         k           <= '0;
         sum         <= '0;
         pix_addr_q  <= '0;
         hist_addr_q <= '0;
      end else begin
         pix_addr_q  <= pix_addr;
         hist_addr_q <= hist_addr;
         case (state)
            IDLE: if (accept) begin
               if (opcode == 4'h1) begin
                  state <= CLR;
                  bin   <= '0;
               end else if (opcode == 4'h2) begin
                  state <= C_RD;
                  bin   <= '0;
                  sum   <= '0;
               end else begin
                  state <= M_PRD;
                  k     <= '0;
               end
            end
            CLR: if (bin == 8'hFF) begin
               state <= H_PRD;
               k     <= '0;
            end else begin
               bin <= bin + 8'd1;
            end
            H_PRD: state <= H_HRD;
            H_HRD: state <= H_HWR;
            H_HWR: if (k == K_LAST) begin
               state <= DONE;
            end else begin
               k     <= k + (ADDR_W+1)'(1);
               state <= H_PRD;
            end
            C_RD: state <= C_WR;
            C_WR: begin
               sum <= sum_nxt;
               if (bin == 8'hFF) begin
                  state <= DONE;
               end else begin
                  bin   <= bin + 8'd1;
                  state <= C_RD;
               end
            end
            M_PRD: state <= M_HRD;
            M_HRD: state <= M_PWR;
            M_PWR: if (k == K_LAST) begin
               state <= DONE;
            end else begin
               k     <= k + (ADDR_W+1)'(1);
               state <= M_PRD;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Addresses hold their last driven value; enables and write data are strobes.
   always_comb begin
      pix_addr   = pix_addr_q;
      hist_addr  = hist_addr_q;
      pix_re     = 1'b0;
      pix_we     = 1'b0;
      pix_wdata  = '0;
      hist_re    = 1'b0;
      hist_we    = 1'b0;
      hist_wdata = '0;
      done       = 1'b0;
      case (state)
         CLR: begin
            hist_we   = 1'b1;
            hist_addr = bin;
         end
         H_PRD, M_PRD: begin
            pix_re   = 1'b1;
            pix_addr = k[ADDR_W-1:0];
         end
         H_HRD, M_HRD: begin
            hist_re   = 1'b1;
            hist_addr = pix_rdata;
         end
         H_HWR: begin
            hist_we    = 1'b1;
            hist_wdata = hist_rdata + HIST_W'(1);
         end
         C_RD: begin
            hist_re   = 1'b1;
            hist_addr = bin;
         end
         C_WR: begin
            hist_we    = 1'b1;
            hist_addr  = bin;
            hist_wdata = sum_nxt;
         end
         M_PWR: begin
            pix_we    = 1'b1;
            pix_addr  = k[ADDR_W-1:0];
            pix_wdata = map_val;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

`ifdef SPU_CYCLE_CNT_EN
   logic [31:0] cyc_cnt;
   logic [31:0] cyc_inc;
   logic [31:0] cyc_last;

   assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

   // The DONE cycle itself is busy, so the captured value includes it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_cnt  <= '0;
         cyc_last <= '0;
      end else if (accept) begin
         cyc_cnt <= '0;
      end else if (busy) begin
         cyc_cnt <= cyc_inc;
         if (state == DONE) cyc_last <= cyc_inc;
      end
   end

   assign cycle_count = cyc_last;
`else
   assign cycle_count = '0;
`endif
endmodule
